seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive matching samples required before a pattern is accepted (legal range 1..255).
REQ-002 SHALL have parameter ACTIVE_LOW, default 1, meaning the input segments are active-low (a lit segment is 0).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port seven_seg, input, 7 bits: segment pattern, bit0=a through bit6=g, asynchronous to the pattern source.
REQ-006 SHALL have port value, output, 4 bits: hex digit of the last accepted legal pattern.
REQ-007 SHALL have port valid, output, 1 bit: high while the stable pattern is a legal hex glyph.
REQ-008 SHALL have port invalid, output, 1 bit: high while the stable pattern is not a legal glyph.
REQ-009 SHALL have port change, output, 1 bit: one-cycle pulse when value is updated.
REQ-010 SHALL have port err_count, output, 8 bits: count of illegal patterns accepted.

Function
REQ-011 SHALL invert seven_seg before decoding when ACTIVE_LOW=1 and use it unmodified when ACTIVE_LOW=0.
REQ-012 SHALL recognise these active-high gfedcba glyphs: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex); every other pattern is illegal.
REQ-013 SHALL register seven_seg into samp on every edge and keep a stability counter cnt that saturates at STABLE_CYCLES.
REQ-014 SHALL clear cnt to 0 on any edge where seven_seg differs from samp, and increment cnt otherwise.
REQ-015 SHALL implement FSM states SETTLE and LOCKED, with reset entering SETTLE.
REQ-016 SHALL move SETTLE to LOCKED on the edge where cnt reaches STABLE_CYCLES, giving valid or invalid high STABLE_CYCLES+1 edges after a new pattern is first sampled.
REQ-017 SHALL, on entering LOCKED with a legal pattern, set valid=1 and invalid=0, load value, and pulse change only if the decoded digit differs from value or valid was 0 on the last lock.
REQ-018 SHALL, on entering LOCKED with an illegal pattern, set invalid=1 and valid=0, hold value, and increment err_count.
REQ-019 SHALL saturate err_count at 255 with no wrap.
REQ-020 SHALL return LOCKED to SETTLE on any input mismatch, clearing valid and invalid on that same edge while value holds.
REQ-021 SHALL treat a glitch shorter than STABLE_CYCLES samples as follows: it produces no change pulse and no err_count increment, and valid/invalid deassert only for the glitch plus resettle window.
REQ-022 SHALL keep the change pulse exactly one cycle, with no pulse while LOCKED and stable.

Reset
REQ-023 SHALL, on reset, set value=0, valid=0, invalid=0, change=0, err_count=0, cnt=0, samp=0 and state SETTLE.
REQ-024 SHALL give reset priority over all other activity, including mid-settle or mid-lock, and SHALL NOT emit a change pulse on the cycle following reset.

Configuration
REQ-025 SHALL compile the error counter only when SEG7_READER_ERRCNT_EN is defined, with err_count behaving per REQ-018/019.
REQ-026 SHALL, when SEG7_READER_ERRCNT_EN is undefined, tie err_count to constant 0 and synthesise no counter logic, leaving invalid unaffected.

Structure
REQ-027 SHALL take the glyph constants (REQ-012), the FSM state encoding and the segment bit-index constants from a shared package seg7_pkg.
REQ-028 SHALL place the combinational glyph-to-digit lookup in one sub-module seg7_glyph_decode with outputs digit[3:0] and legal.

Verification
REQ-029 SHALL cover this scenario: reset, then seven_seg=7'h40 (ACTIVE_LOW, glyph 0) held -> valid=1 and value=0 at the 5th edge after the first sample, change pulses once.
REQ-030 SHALL cover this scenario: glyph 0, then 7'h79 (glyph 1) held -> valid drops 1 cycle, returns after 5 edges with value=1 and a single change pulse.
REQ-031 SHALL cover this scenario: a stable 0, then a 2-cycle glitch to 7'h00, then back to 7'h40 -> no change pulse, err_count unchanged, value stays 0.
REQ-032 SHALL cover this scenario: illegal pattern 7'h7E held 5 edges -> invalid=1, valid=0, err_count=1; repeated 300 times -> err_count=255.
REQ-033 SHALL cover this scenario: reset asserted at cnt=2 while settling glyph 5 -> all outputs 0 next cycle, and the full STABLE_CYCLES window is required afterwards.
REQ-034 SHALL cover this scenario: ACTIVE_LOW=0 with all 16 glyphs swept at 10-cycle spacing -> 16 change pulses, value tracking 0..F.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment reader: segment bit positions,
// active-high gfedcba glyph codes for the sixteen hex digits, the reader FSM
// state encoding and the counter widths.
package seg7_pkg;

    // Segment bit positions inside the 7-bit pattern (bit0 = a ... bit6 = g).
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int SEG_W = 7;

    // Active-high glyph codes, one per hex digit.
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

    // Stability counter and error counter widths.
    localparam int CNT_W = 8;
    localparam int ERR_W = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = 8'hFF;

    // Reader FSM: SETTLE waits for a stable pattern, LOCKED holds a verdict.
    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Normalise a raw pattern to active-high segments.
    function automatic logic [SEG_W-1:0] to_active_high(input logic [SEG_W-1:0] raw,
                                                         input bit active_low);
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-digit lookup. Takes an active-high gfedcba pattern
// and reports the hex digit it shows plus whether it is one of the sixteen
// recognised glyphs. Unrecognised patterns report digit 0 with legal low.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] segs,
    output logic [3:0]       digit,
    output logic             legal
);

    // Exact-match lookup against the glyph table; anything else is illegal.
    always_comb begin
        digit = 4'h0;
        legal = 1'b1;
        case (segs)
            GLYPH_0: digit = 4'h0;
            GLYPH_1: digit = 4'h1;
            GLYPH_2: digit = 4'h2;
            GLYPH_3: digit = 4'h3;
            GLYPH_4: digit = 4'h4;
            GLYPH_5: digit = 4'h5;
            GLYPH_6: digit = 4'h6;
            GLYPH_7: digit = 4'h7;
            GLYPH_8: digit = 4'h8;
            GLYPH_9: digit = 4'h9;
            GLYPH_A: digit = 4'hA;
            GLYPH_B: digit = 4'hB;
            GLYPH_C: digit = 4'hC;
            GLYPH_D: digit = 4'hD;
            GLYPH_E: digit = 4'hE;
            GLYPH_F: digit = 4'hF;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Seven-segment display reader. Samples an asynchronous segment bus, waits
// for STABLE_CYCLES consecutive matching samples, then decodes the pattern
// into a hex digit (valid) or flags it as illegal (invalid).
//
// Optional feature: define SEG7_READER_ERRCNT_EN to build the saturating
// illegal-pattern counter behind err_count; otherwise err_count is tied to 0.
//
// Handshake: there is no ready; value is qualified by valid, and change is a
// single-cycle strobe that fires on the edge value is (re)loaded with a new
// digit or after a lock that was not legal.
// fsm_state exposes the reader FSM for observation.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEG_W-1:0] seven_seg,
    output logic [3:0]       value,
    output logic             valid,
    output logic             invalid,
    output logic             change,
    output logic [ERR_W-1:0] err_count,
    output state_e           fsm_state
);

    localparam logic [CNT_W-1:0] STABLE_L = CNT_W'(STABLE_CYCLES);

    logic [SEG_W-1:0] samp_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic [3:0]       value_q, value_d;
    logic             valid_q, valid_d;
    logic             invalid_q, invalid_d;
    logic             change_q, change_d;
    logic             last_legal_q, last_legal_d;

    logic             match;
    logic             lock_evt;
    logic             unlock_evt;
    logic [SEG_W-1:0] segs_hi;
    logic [3:0]       dec_digit;
    logic             dec_legal;

    // The live input agrees with the previous sample.
    assign match = (seven_seg == samp_q);

    // Decode the registered sample; at a lock edge it equals the live input.
    assign segs_hi = to_active_high(samp_q, ACTIVE_LOW);

    seg7_glyph_decode u_decode (
        .segs  (segs_hi),
        .digit (dec_digit),
        .legal (dec_legal)
    );

    // Stability counter: restart on any change, otherwise count up and stick.
    always_comb begin
        cnt_d = '0;
        if (match) begin
            cnt_d = (cnt_q >= STABLE_L) ? STABLE_L : cnt_q + 8'd1;
        end
    end

    // Sample register and stability counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            samp_q <= '0;
            cnt_q  <= '0;
        end else begin
            samp_q <= seven_seg;
            cnt_q  <= cnt_d;
        end
    end

    // FSM next state: lock when the count first reaches the threshold,
    // unlock on the first sample that differs.
    always_comb begin
        state_d    = state_q;
        lock_evt   = 1'b0;
        unlock_evt = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (match && (cnt_d == STABLE_L)) begin
                    state_d  = ST_LOCKED;
                    lock_evt = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!match) begin
                    state_d    = ST_SETTLE;
                    unlock_evt = 1'b1;
                end
            end
            default: begin
                state_d = ST_SETTLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Verdict outputs: load on lock, clear flags on unlock, value always holds
    // except on a legal lock. change fires when the digit differs or when the
    // previous lock did not produce a legal digit.
    always_comb begin
        value_d      = value_q;
        valid_d      = valid_q;
        invalid_d    = invalid_q;
        change_d     = 1'b0;
        last_legal_d = last_legal_q;
        if (lock_evt) begin
            if (dec_legal) begin
                valid_d      = 1'b1;
                invalid_d    = 1'b0;
                value_d      = dec_digit;
                change_d     = (dec_digit != value_q) || !last_legal_q;
                last_legal_d = 1'b1;
            end else begin
                valid_d      = 1'b0;
                invalid_d    = 1'b1;
                last_legal_d = 1'b0;
            end
        end else if (unlock_evt) begin
            valid_d   = 1'b0;
            invalid_d = 1'b0;
        end
    end

    // Verdict registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q      <= 4'h0;
            valid_q      <= 1'b0;
            invalid_q    <= 1'b0;
            change_q     <= 1'b0;
            last_legal_q <= 1'b0;
        end else begin
            value_q      <= value_d;
            valid_q      <= valid_d;
            invalid_q    <= invalid_d;
            change_q     <= change_d;
            last_legal_q <= last_legal_d;
        end
    end

`ifdef SEG7_READER_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    // Count illegal locks, sticking at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if (lock_evt && !dec_legal && (err_q != ERR_MAX)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = '0;
`endif

    assign value     = value_q;
    assign valid     = valid_q;
    assign invalid   = invalid_q;
    assign change    = change_q;
    assign fsm_state = state_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Testbench for seg7_reader. Two instances: u_al (ACTIVE_LOW=1) and u_ah
// (ACTIVE_LOW=0), both STABLE_CYCLES=4. A behavioural model tracks the
// run length of each input and decides verdicts from the glyph table; a
// compare process checks every output each cycle, and directed scenarios
// pin the model with literal expectations.
module tb_seg7_reader;
    import seg7_pkg::*;

    localparam int STABLE = 4;
`ifdef SEG7_READER_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, reset_b;
    logic [6:0] seg_a, seg_b;
    logic [3:0] value_a, value_b;
    logic       valid_a, valid_b, invalid_a, invalid_b, change_a, change_b;
    logic [7:0] err_a, err_b;
    state_e     fsm_a, fsm_b;

    seg7_reader #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1)) u_al (
        .clk(clk), .reset(reset_a), .seven_seg(seg_a), .value(value_a),
        .valid(valid_a), .invalid(invalid_a), .change(change_a),
        .err_count(err_a), .fsm_state(fsm_a)
    );

    seg7_reader #(.STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b0)) u_ah (
        .clk(clk), .reset(reset_b), .seven_seg(seg_b), .value(value_b),
        .valid(valid_b), .invalid(invalid_b), .change(change_b),
        .err_count(err_b), .fsm_state(fsm_b)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int pulses_a = 0;
    int pulses_b = 0;

    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];

    logic [6:0] glyph_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] m_samp[2];
    int         m_run[2];
    bit         m_locked[2];
    bit         m_lastok[2];
    logic [3:0] m_value[2];
    bit         m_valid[2], m_invalid[2], m_change[2];
    int         m_err[2];

    function automatic int lookup(input logic [6:0] hi);
        int r = -1;
        for (int k = 0; k < 16; k++) if (glyph_tab[k] == hi) r = k;
        return r;
    endfunction

    task automatic model_reset(input int i);
        m_samp[i] = '0; m_run[i] = 0; m_locked[i] = 0; m_lastok[i] = 0;
        m_value[i] = '0; m_valid[i] = 0; m_invalid[i] = 0; m_change[i] = 0;
        m_err[i] = 0;
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
    endtask

    task automatic model_step(input int i, input bit rst, input logic [6:0] x, input bit act_low);
        int d;
        if (rst) begin
            model_reset(i);
        end else begin
            m_change[i] = 0;
            if (x != m_samp[i]) begin
                m_samp[i] = x;
                m_run[i] = 0;
                if (m_locked[i]) begin
                    m_locked[i] = 0; m_valid[i] = 0; m_invalid[i] = 0;
                end
            end else begin
                if (m_run[i] < STABLE) m_run[i]++;
                if (!m_locked[i] && m_run[i] == STABLE) begin
                    m_locked[i] = 1;
                    d = lookup(act_low ? ~x : x);
                    if (d >= 0) begin
                        if (!m_lastok[i] || d != int'(m_value[i])) begin
                            m_change[i] = 1;
                            if (i == 0) exp_q0.push_back(d[3:0]); else exp_q1.push_back(d[3:0]);
                        end
                        m_value[i] = d[3:0]; m_valid[i] = 1; m_invalid[i] = 0; m_lastok[i] = 1;
                    end else begin
                        m_valid[i] = 0; m_invalid[i] = 1; m_lastok[i] = 0;
                        if (ERR_EN && m_err[i] < 255) m_err[i]++;
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk);
            model_step(0, reset_a, seg_a, 1'b1);
            model_step(1, reset_b, seg_b, 1'b0);
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("a_value", value_a, m_value[0]);
                chk("a_valid", valid_a, m_valid[0]);
                chk("a_invalid", invalid_a, m_invalid[0]);
                chk("a_change", change_a, m_change[0]);
                chk("a_err", err_a, m_err[0]);
                chk("a_state", int'(fsm_a), m_locked[0] ? int'(ST_LOCKED) : int'(ST_SETTLE));
                chk("b_value", value_b, m_value[1]);
                chk("b_valid", valid_b, m_valid[1]);
                chk("b_invalid", invalid_b, m_invalid[1]);
                chk("b_change", change_b, m_change[1]);
                chk("b_err", err_b, m_err[1]);
                chk("b_state", int'(fsm_b), m_locked[1] ? int'(ST_LOCKED) : int'(ST_SETTLE));
                if (change_a === 1'b1) begin
                    pulses_a++;
                    chk("sb_a_pending", int'(exp_q0.size() > 0), 1);
                    if (exp_q0.size() > 0) chk("sb_a_value", value_a, exp_q0.pop_front());
                end
                if (change_b === 1'b1) begin
                    pulses_b++;
                    chk("sb_b_pending", int'(exp_q1.size() > 0), 1);
                    if (exp_q1.size() > 0) chk("sb_b_value", value_b, exp_q1.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        int hold_a, hold_b;
        int g;
        reset_a = 1'b1; reset_b = 1'b1;
        seg_a = 7'h7F; seg_b = 7'h00;
        tick(2);
        cmp_en = 1'b1;
        chk("rst_value", value_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_invalid", invalid_a, 0);
        chk("rst_change", change_a, 0);
        chk("rst_err", err_a, 0);

        // Glyph 0 (active-low 40): valid at the 5th edge, one change pulse.
        p0 = pulses_a;
        reset_a = 1'b0; reset_b = 1'b0; seg_a = 7'h40;
        tick(4);
        chk("g0_valid_early", valid_a, 0);
        tick(1);
        chk("g0_valid", valid_a, 1);
        chk("g0_value", value_a, 0);
        chk("g0_change", change_a, 1);
        tick(1);
        chk("g0_change_once", change_a, 0);
        chk("g0_pulses", pulses_a - p0, 1);

        // Glyph 1 (active-low 79): valid drops, returns after 5 edges.
        p0 = pulses_a;
        seg_a = 7'h79;
        tick(1);
        chk("g1_valid_drop", valid_a, 0);
        chk("g1_value_hold", value_a, 0);
        tick(3);
        chk("g1_valid_low", valid_a, 0);
        tick(1);
        chk("g1_valid", valid_a, 1);
        chk("g1_value", value_a, 1);
        tick(2);
        chk("g1_pulses", pulses_a - p0, 1);

        // Stable 0, then a 2-cycle glitch to 00, then back to 40.
        seg_a = 7'h40;
        tick(6);
        p0 = pulses_a;
        seg_a = 7'h00;
        tick(2);
        seg_a = 7'h40;
        tick(6);
        chk("glitch_pulses", pulses_a - p0, 0);
        chk("glitch_value", value_a, 0);
        chk("glitch_valid", valid_a, 1);
        chk("glitch_err", err_a, 0);

        // Illegal 7E held 5 edges, then 300 repetitions saturate the counter.
        seg_a = 7'h7E;
        tick(5);
        chk("ill_invalid", invalid_a, 1);
        chk("ill_valid", valid_a, 0);
        chk("ill_value_hold", value_a, 0);
        chk("ill_err1", err_a, ERR_EN ? 1 : 0);
        for (int r = 1; r < 300; r++) begin
            seg_a = 7'h7F;
            tick(1);
            seg_a = 7'h7E;
            tick(5);
        end
        chk("ill_err_sat", err_a, ERR_EN ? 255 : 0);
        chk("ill_invalid_end", invalid_a, 1);

        // Reset while settling glyph 5 (active-low 12) at cnt=2.
        seg_a = 7'h12;
        tick(3);
        reset_a = 1'b1;
        tick(1);
        chk("rst5_value", value_a, 0);
        chk("rst5_valid", valid_a, 0);
        chk("rst5_invalid", invalid_a, 0);
        chk("rst5_change", change_a, 0);
        chk("rst5_err", err_a, 0);
        reset_a = 1'b0;
        tick(1);
        chk("rst5_no_pulse", change_a, 0);
        tick(3);
        chk("rst5_valid_early", valid_a, 0);
        tick(1);
        chk("rst5_valid", valid_a, 1);
        chk("rst5_value", value_a, 5);
        chk("rst5_change_after", change_a, 1);

        // Active-high instance: sweep all 16 glyphs at 10-cycle spacing.
        reset_b = 1'b1;
        tick(1);
        reset_b = 1'b0;
        p0 = pulses_b;
        for (int d = 0; d < 16; d++) begin
            seg_b = glyph_tab[d];
            tick(10);
            chk("sweep_value", value_b, d);
            chk("sweep_valid", valid_b, 1);
        end
        chk("sweep_pulses", pulses_b - p0, 16);

        // Randomised phase on both instances.
        hold_a = 0; hold_b = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_a == 0) begin
                g = int'($urandom_range(0, 15));
                seg_a = ($urandom_range(0, 1) == 0) ? ~glyph_tab[g] : 7'($urandom_range(0, 127));
                hold_a = int'($urandom_range(1, 9));
            end
            if (hold_b == 0) begin
                g = int'($urandom_range(0, 15));
                seg_b = ($urandom_range(0, 1) == 0) ? glyph_tab[g] : 7'($urandom_range(0, 127));
                hold_b = int'($urandom_range(1, 9));
            end
            hold_a--; hold_b--;
            reset_a = ($urandom_range(0, 249) == 0);
            reset_b = ($urandom_range(0, 249) == 0);
            tick(1);
        end
        reset_a = 1'b0; reset_b = 1'b0;
        tick(10);

        chk("sb_a_drain", exp_q0.size(), 0);
        chk("sb_b_drain", exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
